// File: rtl/loader_pkg.sv
// Shared types and defaults for the program memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int DEFAULT_CHK_SIZE = 8;

endpackage

// File: rtl/loader_checksum.sv
// Additive modular checksum accumulator with synchronous clear and add enable.
module loader_checksum
  import loader_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int CHK_SIZE  = DEFAULT_CHK_SIZE
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] add_data,
  output logic [CHK_SIZE-1:0]  sum
);

  logic [CHK_SIZE-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + CHK_SIZE'(add_data);
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Streams an instruction image into program memory, reads it back to verify an
// additive checksum, and holds the core stalled until the image is verified.
module prog_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5,
  parameter int CHK_SIZE  = DEFAULT_CHK_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 cpu_hold,
  output logic [ADDR_SIZE:0]   load_len,
  output logic                 done,
  output logic                 error
);

  localparam int               LEN_W     = ADDR_SIZE + 1;
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'((1 << ADDR_SIZE) - 1);

  loader_state_t       state_q, state_d;
  logic [LEN_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]    load_len_q, load_len_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                vld_p0, vld_p1;
  logic                accept, rd_issue, verify_end, start_ok;
  logic [CHK_SIZE-1:0] sum_w, sum_r;

  assign in_ready   = (state_q == ST_LOAD);
  assign accept     = in_ready & in_valid;
  assign mem_we     = accept;
  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign rd_issue   = (state_q == ST_VERIFY) && (rd_ptr_q < load_len_q);
  // Readback finishes once every address is issued and the last read has drained.
  assign verify_end = (state_q == ST_VERIFY) && !rd_issue && !vld_p1;
  assign vld_p0     = rd_issue;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept) begin
      mem_addr  = wr_ptr_q[ADDR_SIZE-1:0];
      mem_wdata = in_data;
    end else if (rd_issue) begin
      mem_addr = rd_ptr_q[ADDR_SIZE-1:0];
    end
  end

  loader_checksum #(
    .DATA_SIZE(DATA_SIZE),
    .CHK_SIZE (CHK_SIZE)
  ) u_sum_w (
    .clk     (clk),
    .clr     (start_ok),
    .en      (accept),
    .add_data(in_data),
    .sum     (sum_w)
  );

  loader_checksum #(
    .DATA_SIZE(DATA_SIZE),
    .CHK_SIZE (CHK_SIZE)
  ) u_sum_r (
    .clk     (clk),
    .clr     (start_ok),
    .en      (vld_p1),
    .add_data(mem_rdata),
    .sum     (sum_r)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    load_len_d = load_len_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          load_len_d = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (in_last) begin
            load_len_d = wr_ptr_q + ONE;
            state_d    = ST_VERIFY;
          end else if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + ONE;
        end
        if (verify_end) begin
          if (sum_r == sum_w) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_hold_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      load_len_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      load_len_q <= load_len_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
      vld_p1     <= vld_p0;
    end
  end

  assign cpu_hold = cpu_hold_q;
  assign load_len = load_len_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: expected writes and completions are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_prog_mem_loader;

  localparam int DATA_SIZE = 6;
  localparam int ADDR_SIZE = 5;
  localparam int CHK_SIZE  = 8;

  typedef struct {
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] data;
  } wr_t;

  typedef struct {
    logic       done;
    logic       err;
    logic [5:0] len;
    int         lat;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [DATA_SIZE-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata = '0;
  logic                 cpu_hold;
  logic [ADDR_SIZE:0]   load_len;
  logic                 done;
  logic                 error;

  logic [DATA_SIZE-1:0] mem [32];
  logic                 corrupt = 1'b0;

  wr_t  exp_wr [$];
  res_t exp_res[$];
  wr_t  mon_w;
  res_t mon_r;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   exp_addr = 0;
  logic prev_fin = 1'b0;

  prog_mem_loader #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .CHK_SIZE (CHK_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_hold (cpu_hold),
    .load_len (load_len),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read program memory; optional single-bit corruption on address 2.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 5'd2) ? 6'h01 : 6'h00);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and completions whenever the DUT presents them.
  always @(negedge clk) begin
    if (mem_we) begin
      last_acc = cyc + 1;
      if (exp_wr.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", mem_addr, mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("write_addr", int'(mem_addr), int'(mon_w.addr));
        chk("write_data", int'(mem_wdata), int'(mon_w.data));
      end
    end
    if ((done | error) && !prev_fin) begin
      if (exp_res.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_complete: got done=%0d error=%0d, required none", done, error);
      end else begin
        mon_r = exp_res.pop_front();
        chk("end_done", int'(done), int'(mon_r.done));
        chk("end_error", int'(error), int'(mon_r.err));
        chk("end_load_len", int'(load_len), int'(mon_r.len));
        chk("end_latency", cyc - last_acc, mon_r.lat);
        chk("end_cpu_hold", int'(cpu_hold), int'(mon_r.err));
      end
    end
    prev_fin = done | error;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic d, input logic e, input int len, input int lat);
    res_t r;
    r.done = d;
    r.err  = e;
    r.len  = 6'(len);
    r.lat  = lat;
    exp_res.push_back(r);
  endtask

  task automatic send_beat(input logic [DATA_SIZE-1:0] d, input logic last);
    wr_t w;
    logic acc;
    w.addr = 5'(exp_addr);
    w.data = d;
    exp_wr.push_back(w);
    exp_addr++;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (!acc) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_complete(input int maxc);
    logic seen;
    seen = done | error;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      seen = done | error;
    end
    chk("complete_seen", int'(seen), 1);
  endtask

  task automatic do_start(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = 6'h15;
    @(negedge clk);
    chk("start_cycle_in_ready", int'(in_ready), 0);
    chk("start_cycle_mem_we", int'(mem_we), 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    exp_addr = 0;
    chk("load_in_ready", int'(in_ready), 1);
    chk("load_cpu_hold", int'(cpu_hold), 1);
    chk("load_done_clr", int'(done), 0);
    chk("load_error_clr", int'(error), 0);
    chk("load_len_clr", int'(load_len), 0);
  endtask

  task automatic check_reset();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_load_len", int'(load_len), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check_reset();
    rst = 1'b0;
    step();

    // Four-word image: done six cycles after the last beat.
    push_res(1'b1, 1'b0, 4, 6);
    do_start(1'b0);
    send_beat(6'h01, 1'b0);
    send_beat(6'h2A, 1'b0);
    send_beat(6'h3F, 1'b0);
    send_beat(6'h10, 1'b1);
    wait_complete(20);
    chk("t1_done", int'(done), 1);
    chk("t1_cpu_hold", int'(cpu_hold), 0);
    chk("t1_load_len", int'(load_len), 4);
    chk("t1_mem0", int'(mem[0]), 'h01);
    chk("t1_mem1", int'(mem[1]), 'h2A);
    chk("t1_mem2", int'(mem[2]), 'h3F);
    chk("t1_mem3", int'(mem[3]), 'h10);

    // Full-depth image with idle gaps between beats.
    push_res(1'b1, 1'b0, 32, 34);
    do_start(1'b0);
    for (int i = 0; i < 32; i++) begin
      send_beat(6'((i * 11 + 5) & 63), i == 31);
      repeat (i % 3) step();
    end
    wait_complete(60);
    chk("t2_done", int'(done), 1);
    chk("t2_load_len", int'(load_len), 32);
    chk("t2_mem31", int'(mem[31]), (31 * 11 + 5) & 63);

    // Overflow: 32 beats with no last marker.
    push_res(1'b0, 1'b1, 0, 0);
    do_start(1'b0);
    for (int i = 0; i < 32; i++) send_beat(6'(63 - i), 1'b0);
    wait_complete(5);
    chk("t3_error", int'(error), 1);
    chk("t3_done", int'(done), 0);
    chk("t3_in_ready", int'(in_ready), 0);
    chk("t3_cpu_hold", int'(cpu_hold), 1);
    chk("t3_mem31", int'(mem[31]), 'h20);
    in_valid = 1'b1;
    in_data  = 6'h3F;
    repeat (4) begin
      @(negedge clk);
      chk("t3_beat33_in_ready", int'(in_ready), 0);
      chk("t3_beat33_mem_we", int'(mem_we), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Readback corruption at address 2.
    corrupt = 1'b1;
    push_res(1'b0, 1'b1, 4, 6);
    do_start(1'b0);
    send_beat(6'h01, 1'b0);
    send_beat(6'h2A, 1'b0);
    send_beat(6'h3F, 1'b0);
    send_beat(6'h10, 1'b1);
    wait_complete(20);
    chk("t4_error", int'(error), 1);
    chk("t4_done", int'(done), 0);
    chk("t4_cpu_hold", int'(cpu_hold), 1);
    corrupt = 1'b0;

    // Reset in the middle of a load, then a clean load with start+valid together.
    do_start(1'b0);
    send_beat(6'h01, 1'b0);
    send_beat(6'h2A, 1'b0);
    rst = 1'b1;
    step();
    check_reset();
    rst = 1'b0;
    step();
    push_res(1'b1, 1'b0, 4, 6);
    do_start(1'b1);
    send_beat(6'h05, 1'b0);
    send_beat(6'h0A, 1'b0);
    send_beat(6'h14, 1'b0);
    send_beat(6'h28, 1'b1);
    wait_complete(20);
    chk("t5_done", int'(done), 1);
    chk("t5_cpu_hold", int'(cpu_hold), 0);

    // Start is ignored during LOAD and VERIFY.
    push_res(1'b1, 1'b0, 4, 6);
    do_start(1'b0);
    send_beat(6'h11, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_load_in_ready", int'(in_ready), 1);
    send_beat(6'h22, 1'b0);
    send_beat(6'h33, 1'b0);
    send_beat(6'h04, 1'b1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_verify_in_ready", int'(in_ready), 0);
    wait_complete(20);
    chk("t6_done", int'(done), 1);

    // Start from DONE reasserts hold and reloads from address 0.
    push_res(1'b1, 1'b0, 3, 5);
    do_start(1'b0);
    send_beat(6'h3A, 1'b0);
    send_beat(6'h1B, 1'b0);
    send_beat(6'h2C, 1'b1);
    wait_complete(20);
    chk("t6_reload_len", int'(load_len), 3);
    chk("t6_reload_mem0", int'(mem[0]), 'h3A);
    chk("t6_reload_mem2", int'(mem[2]), 'h2C);

    repeat (3) step();
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
